// File: rtl/morph_sequencer.sv
// rtl/morph_sequencer.sv - frame sequencer for the 1-bit morphological window processor
module morph_sequencer #(
    parameter int AW        = 15,
    parameter int NPIX      = 32768,
    parameter int FLUSH_CYC = 514,
    parameter int RD_LAT    = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    op,
    output logic          busy,
    output logic          done,
    output logic          pass_idx,
    output logic          mem_rd,
    output logic          mem_we,
    output logic [AW:0]   mem_addr,
    output logic          mem_wdata,
    input  logic          mem_rdata,
    output logic          proc_which,
    output logic          proc_income,
    output logic [AW-1:0] proc_addr,
    input  logic          proc_outcome
);

    // Counters carry one extra bit so a full 2**AW frame ends without wrapping.
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] NPIX_C     = CW'(NPIX);
    localparam logic [CW-1:0] FEED_LAST  = CW'(NPIX);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(FLUSH_CYC - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(NPIX + RD_LAT - 1);
    localparam logic [CW-1:0] LAT_C      = CW'(RD_LAT);
    localparam logic [AW-1:0] FLUSH_BASE = AW'(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_FLUSH,
        S_DRAIN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    op_q, op_d;
    logic          pass_q, pass_d;

    // State, phase counter, latched op and pass index.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'b00;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            pass_q  <= pass_d;
        end
    end

    // Pass 0 reads bank 0; the second pass of open/close reads back what pass 0 wrote.
    assign pass_idx   = pass_q;
    assign proc_which = pass_q ? ~op_q[0] : op_q[0];

    // Next-state logic and all per-phase strobes, addresses and data steering.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        pass_d      = pass_q;
        busy        = 1'b0;
        done        = 1'b0;
        mem_rd      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = 1'b0;
        proc_income = 1'b0;
        proc_addr   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    pass_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                busy = 1'b1;
                if (cnt_q < NPIX_C) begin
                    mem_rd   = 1'b1;
                    mem_addr = {pass_q, cnt_q[AW-1:0]};
                end
                // RAM data lags the read by one cycle, so pixel i lands on cycle i+1.
                if (cnt_q != '0) begin
                    proc_income = mem_rdata;
                    proc_addr   = cnt_q[AW-1:0] - AW'(1);
                end
                if (cnt_q == FEED_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FLUSH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FLUSH: begin
                busy      = 1'b1;
                proc_addr = FLUSH_BASE + cnt_q[AW-1:0];
                if (cnt_q == FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (cnt_q < NPIX_C) begin
                    proc_addr = cnt_q[AW-1:0];
                end
                // Write back each result once the processor read latency has elapsed.
                if (cnt_q >= LAT_C) begin
                    mem_we    = 1'b1;
                    mem_addr  = {~pass_q, cnt_q[AW-1:0] - AW'(RD_LAT)};
                    mem_wdata = proc_outcome;
                end
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = (op_q[1] && !pass_q) ? S_NEXT : S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                busy    = 1'b1;
                pass_d  = 1'b1;
                cnt_d   = '0;
                state_d = S_FEED;
            end
            S_DONE: begin
                done    = 1'b1;
                pass_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_morph_sequencer.sv
// tb/tb_morph_sequencer.sv - self-checking bench for morph_sequencer
module tb_morph_sequencer;

    localparam int AW     = 4;
    localparam int NPIX   = 16;
    localparam int FLUSH  = 4;
    localparam int RD_LAT = 2;
    localparam int L      = (NPIX + 1) + FLUSH + (NPIX + RD_LAT) + 1;
    localparam int BAW    = 7;
    localparam int BNPIX  = 128;
    localparam int BL     = (BNPIX + 1) + FLUSH + (BNPIX + RD_LAT) + 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset, start;
    logic [1:0]    op;
    logic          busy, done, pass_idx, mem_rd, mem_we, mem_wdata, mem_rdata;
    logic [AW:0]   mem_addr;
    logic          proc_which, proc_income, proc_outcome;
    logic [AW-1:0] proc_addr;

    logic           b_start, b_rdata, b_outcome;
    logic [1:0]     b_op;
    logic           b_busy, b_done, b_pass_idx, b_mem_rd, b_mem_we, b_mem_wdata;
    logic [BAW:0]   b_mem_addr;
    logic           b_proc_which, b_proc_income;
    logic [BAW-1:0] b_proc_addr;

    morph_sequencer #(.AW(AW), .NPIX(NPIX), .FLUSH_CYC(FLUSH), .RD_LAT(RD_LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .busy(busy), .done(done), .pass_idx(pass_idx),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .proc_which(proc_which), .proc_income(proc_income),
        .proc_addr(proc_addr), .proc_outcome(proc_outcome)
    );

    morph_sequencer #(.AW(BAW), .NPIX(BNPIX), .FLUSH_CYC(FLUSH), .RD_LAT(RD_LAT)) dut_big (
        .clock(clock), .reset(reset), .start(b_start), .op(b_op),
        .busy(b_busy), .done(b_done), .pass_idx(b_pass_idx),
        .mem_rd(b_mem_rd), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_rdata),
        .proc_which(b_proc_which), .proc_income(b_proc_income),
        .proc_addr(b_proc_addr), .proc_outcome(b_outcome)
    );

    // Frame RAM (1-cycle read) and a processor whose result is addr[0], two cycles late.
    logic [31:0] ram_q;
    logic        load_en;
    logic [15:0] load_data;
    logic        pipe1, pipe2;
    always @(posedge clock) begin
        if (load_en) ram_q[15:0] <= load_data;
        if (mem_we) ram_q[int'(mem_addr)] <= mem_wdata;
        mem_rdata <= mem_rd ? ram_q[int'(mem_addr)] : 1'b0;
        pipe1 <= proc_addr[0];
        pipe2 <= pipe1;
    end
    assign proc_outcome = pipe2;

    // Reference timeline: offset of the current cycle from the accepted start.
    logic       m_active;
    int         m_t;
    logic [1:0] m_op;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_active <= 1'b0;
            m_t      <= 0;
            m_op     <= 2'b00;
        end else if (m_active) begin
            if (m_t == (m_op[1] ? 2 : 1) * L) m_active <= 1'b0;
            else m_t <= m_t + 1;
        end else if (start) begin
            m_active <= 1'b1;
            m_t      <= 1;
            m_op     <= op;
        end
    end

    int          checks, errors;
    int          done_seen, b_done_seen;
    int          first_we_t, first_rd_t, first_rd_addr;
    logic [15:0] exp_bank0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_cycle();
        int t, np, p, u, f, v, src, dst;
        if (done) done_seen++;
        if (b_done) b_done_seen++;
        if (!m_active) begin
            check("idle_outputs", {busy, done, mem_rd, mem_we, proc_income}, 0);
            return;
        end
        t   = m_t;
        np  = m_op[1] ? 2 : 1;
        p   = (t - 1) / L;
        u   = (t - 1) % L;
        src = p;
        dst = (p == 1) ? 0 : 1;
        if (mem_we && first_we_t < 0) first_we_t = t;
        if (mem_rd && first_rd_t < 0) begin
            first_rd_t    = t;
            first_rd_addr = int'(mem_addr);
        end
        check("busy", busy, (t == np * L) ? 0 : 1);
        check("done", done, (t == np * L) ? 1 : 0);
        check("pass_idx", pass_idx, p);
        check("proc_which", proc_which, (p == 1) ? (m_op[0] ? 0 : 1) : int'(m_op[0]));
        if (u <= NPIX) begin
            check("feed_rd", mem_rd, (u < NPIX) ? 1 : 0);
            check("feed_we", mem_we, 0);
            if (u < NPIX) check("feed_addr", int'(mem_addr), src * NPIX + u);
            if (u >= 1) begin
                check("feed_paddr", int'(proc_addr), u - 1);
                check("feed_income", proc_income,
                      (p == 1) ? ((u - 1) & 1) : int'(exp_bank0[u - 1]));
            end
        end else if (u < NPIX + 1 + FLUSH) begin
            f = u - NPIX - 1;
            check("flush_strobes", {mem_rd, mem_we, proc_income}, 0);
            check("flush_paddr", int'(proc_addr), (NPIX + f) % (1 << AW));
        end else if (u < NPIX + 1 + FLUSH + NPIX + RD_LAT) begin
            v = u - NPIX - 1 - FLUSH;
            check("drain_rd_income", {mem_rd, proc_income}, 0);
            if (v < NPIX) check("drain_paddr", int'(proc_addr), v);
            check("drain_we", mem_we, (v >= RD_LAT) ? 1 : 0);
            if (v >= RD_LAT) begin
                check("drain_addr", int'(mem_addr), dst * NPIX + (v - RD_LAT));
                check("drain_wdata", mem_wdata, (v - RD_LAT) & 1);
            end
        end else begin
            check("gap_strobes", {mem_rd, mem_we, proc_income}, 0);
        end
    endtask

    task automatic start_small(input logic [1:0] o, input logic [15:0] pat);
        @(posedge clock); #2;
        load_en = 1'b1; load_data = pat; exp_bank0 = pat;
        start = 1'b1; op = o;
        first_we_t = -1; first_rd_t = -1; first_rd_addr = -1; done_seen = 0;
        @(posedge clock); #2;
        load_en = 1'b0; start = 1'b0;
    endtask

    // Waits for done on the small instance; optionally pulses start at offset pulse_at.
    task automatic wait_small(input int pulse_at, output int lat);
        int k;
        lat = -1;
        k = 0;
        while (lat < 0 && k < 200) begin
            @(negedge clock);
            k++;
            if (pulse_at > 0) begin
                if (k == pulse_at) begin
                    start = 1'b1;
                    op = 2'b10;
                end else begin
                    start = 1'b0;
                end
            end
            if (done) lat = k;
        end
    endtask

    task automatic start_big();
        @(posedge clock); #2;
        b_start = 1'b1;
        @(posedge clock); #2;
        b_start = 1'b0;
    endtask

    initial begin
        int lat, k;
        checks = 0; errors = 0; done_seen = 0; b_done_seen = 0;
        first_we_t = -1; first_rd_t = -1; first_rd_addr = -1;
        exp_bank0 = '0;
        reset = 1'b1; start = 1'b0; op = 2'b00;
        load_en = 1'b0; load_data = '0;
        b_start = 1'b0; b_op = 2'b00; b_rdata = 1'b1; b_outcome = 1'b0;
        fork
            forever begin
                @(negedge clock);
                cmp_cycle();
            end
        join_none

        repeat (2) @(negedge clock);
        #1;
        check("rst_outputs", {busy, done, pass_idx, mem_rd, mem_we, mem_addr, mem_wdata,
                              proc_which, proc_income, proc_addr}, 0);
        check("rst_big_busy", b_busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // Abandon a large-frame erosion at FEED cycle 100 with an asynchronous reset.
        start_big();
        repeat (100) @(posedge clock);
        #2;
        check("pre_rst_busy", b_busy, 1);
        check("pre_rst_rd", b_mem_rd, 1);
        check("pre_rst_addr", int'(b_mem_addr), 100);
        check("pre_rst_income", b_proc_income, 1);
        reset = 1'b1;
        #1;
        check("async_rst_busy", b_busy, 0);
        check("async_rst_rd", b_mem_rd, 0);
        check("async_rst_income", b_proc_income, 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        b_done_seen = 0;
        repeat (300) @(negedge clock);
        check("no_done_after_rst", b_done_seen, 0);
        check("idle_after_rst", b_busy, 0);
        start_big();
        lat = -1;
        k = 0;
        while (lat < 0 && k < 400) begin
            @(negedge clock);
            k++;
            if (b_done) lat = k;
        end
        check("big_latency", lat, BL);
        check("big_done_count", b_done_seen, 1);

        // Erode an all-ones frame: 40 edges from the start cycle to done.
        start_small(2'b00, 16'hFFFF);
        wait_small(0, lat);
        check("op00_latency", lat, 40);
        check("op00_first_write_t", first_we_t, 24);
        check("op00_done_count", done_seen, 1);
        check("op00_bank1", int'(ram_q[31:16]), 16'hAAAA);
        for (int w = 0; w < NPIX; w++) check("op00_bank1_word", ram_q[16 + w], w & 1);

        // Close, issued in the cycle right after the previous done.
        start_small(2'b11, 16'h9249);
        wait_small(0, lat);
        check("op11_latency", lat, 80);
        check("b2b_first_rd_t", first_rd_t, 1);
        check("b2b_first_rd_addr", first_rd_addr, 0);
        check("op11_done_count", done_seen, 1);
        check("op11_bank0", int'(ram_q[15:0]), 16'hAAAA);
        check("op11_bank1", int'(ram_q[31:16]), 16'hAAAA);

        // Dilate with a stray start (op 10) during DRAIN, which must be ignored.
        start_small(2'b01, 16'h3C5A);
        wait_small(30, lat);
        start = 1'b0;
        check("op01_latency", lat, 40);
        repeat (50) @(negedge clock);
        check("op01_done_count", done_seen, 1);
        check("op01_idle_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
